// File: rtl/otter_hazard_unit.sv
// Hazard/forwarding unit for the pipelined OTTER core with a shadow scoreboard of post-decode stages.
// Operand forwarding is built only when OTTER_HAZARD_FWD_EN is defined; otherwise every RAW hazard stalls.
module otter_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   de_valid,
  input  logic [4:0]             de_rs1,
  input  logic [4:0]             de_rs2,
  input  logic                   de_rs1_used,
  input  logic                   de_rs2_used,
  input  logic [4:0]             de_rd,
  input  logic                   de_reg_write,
  input  logic                   de_is_load,
  input  logic                   hold,
  input  logic                   flush,
  input  logic [STAGES*XLEN-1:0] stage_data,
  output logic                   stall,
  output logic                   fwd_a_hit,
  output logic                   fwd_b_hit,
  output logic [XLEN-1:0]        fwd_a_data,
  output logic [XLEN-1:0]        fwd_b_data,
  output logic [31:0]            stall_count
);

  logic [STAGES-1:0]      entValid;
  logic [STAGES-1:0]      entRegWrite;
  logic [STAGES-1:0]      entIsLoad;
  logic [STAGES-1:0][4:0] entRd;

  logic            useA, useB;
  logic            foundA, foundB;
  logic            lateA, lateB;
  logic [XLEN-1:0] dataA, dataB;
  logic            issue;

  assign useA = de_valid && de_rs1_used && (de_rs1 != 5'd0);
  assign useB = de_valid && de_rs2_used && (de_rs2 != 5'd0);

  // Youngest-first search: the first matching entry is latched and older ones are ignored.
  always_comb begin
    foundA = 1'b0;
    foundB = 1'b0;
    lateA  = 1'b0;
    lateB  = 1'b0;
    dataA  = '0;
    dataB  = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (!foundA && useA && entValid[k] && entRegWrite[k] && (entRd[k] == de_rs1)) begin
        foundA = 1'b1;
        lateA  = entIsLoad[k] && (k < LOAD_READY);
        dataA  = stage_data[k*XLEN +: XLEN];
      end
      if (!foundB && useB && entValid[k] && entRegWrite[k] && (entRd[k] == de_rs2)) begin
        foundB = 1'b1;
        lateB  = entIsLoad[k] && (k < LOAD_READY);
        dataB  = stage_data[k*XLEN +: XLEN];
      end
    end
  end

`ifdef OTTER_HAZARD_FWD_EN
  assign stall      = (foundA && lateA) || (foundB && lateB);
  assign fwd_a_hit  = foundA && !lateA;
  assign fwd_b_hit  = foundB && !lateB;
  assign fwd_a_data = fwd_a_hit ? dataA : '0;
  assign fwd_b_data = fwd_b_hit ? dataB : '0;
`else
  logic unusedFwd;
  assign unusedFwd  = lateA ^ lateB ^ (^dataA) ^ (^dataB);
  assign stall      = foundA || foundB;
  assign fwd_a_hit  = 1'b0;
  assign fwd_b_hit  = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_data = '0;
`endif

  assign issue = de_valid && !stall && !flush;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      entValid    <= '0;
      entRegWrite <= '0;
      entIsLoad   <= '0;
      entRd       <= '0;
      stall_count <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
      if (!hold) begin
        entValid    <= {entValid[STAGES-2:0], issue};
        entRegWrite <= {entRegWrite[STAGES-2:0], de_reg_write};
        entIsLoad   <= {entIsLoad[STAGES-2:0], de_is_load};
        entRd       <= {entRd[STAGES-2:0], de_rd};
      end
    end
  end

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Randomized and directed bench for otter_hazard_unit against a queue-based scoreboard model.
module tb_otter_hazard_unit;
  localparam int XLEN       = 32;
  localparam int STAGES     = 3;
  localparam int LOAD_READY = 1;

  logic CLK = 1'b0;
  logic RESET;
  logic de_valid, de_rs1_used, de_rs2_used, de_reg_write, de_is_load, hold, flush;
  logic [4:0] de_rs1, de_rs2, de_rd;
  logic [STAGES*XLEN-1:0] stage_data;
  logic stall, fwd_a_hit, fwd_b_hit;
  logic [XLEN-1:0] fwd_a_data, fwd_b_data;
  logic [31:0] stall_count;

  otter_hazard_unit #(.XLEN(XLEN), .STAGES(STAGES), .LOAD_READY(LOAD_READY)) dut (
    .CLK(CLK), .RESET(RESET), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
    .de_reg_write(de_reg_write), .de_is_load(de_is_load), .hold(hold), .flush(flush),
    .stage_data(stage_data), .stall(stall), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  typedef struct { bit v; int rd; bit rw; bit ld; } ent_t;
  ent_t hist[$];          // hist[k] is what sits in pipeline entry k
  ent_t pend;             // what enters entry 0 at the next edge
  bit pendHold, pendStall;
  longint unsigned mCount;
  int vectors = 0;
  int errors  = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < STAGES; i++) hist.push_back('{v: 0, rd: 0, rw: 0, ld: 0});
    pend = '{v: 0, rd: 0, rw: 0, ld: 0};
    pendHold = 0; pendStall = 0; mCount = 0;
  endtask

  task automatic model_op(input bit used, input int rs, output bit st, output bit hit,
                          output logic [31:0] d);
    st = 0; hit = 0; d = '0;
    if (!(de_valid && used && rs != 0)) return;
    for (int k = 0; k < hist.size(); k++) begin
      if (hist[k].v && hist[k].rw && hist[k].rd == rs) begin
`ifdef OTTER_HAZARD_FWD_EN
        if (hist[k].ld && k < LOAD_READY) st = 1;
        else begin hit = 1; d = stage_data[k*XLEN +: XLEN]; end
`else
        st = 1;
`endif
        return;
      end
    end
  endtask

  task automatic check();
    bit sa, sb, ha, hb;
    logic [31:0] da, db;
    model_op(de_rs1_used, int'(de_rs1), sa, ha, da);
    model_op(de_rs2_used, int'(de_rs2), sb, hb, db);
    vectors++;
    cmp("stall", {31'd0, stall}, {31'd0, sa | sb});
    cmp("fwd_a_hit", {31'd0, fwd_a_hit}, {31'd0, ha});
    cmp("fwd_b_hit", {31'd0, fwd_b_hit}, {31'd0, hb});
    cmp("fwd_a_data", fwd_a_data, da);
    cmp("fwd_b_data", fwd_b_data, db);
    cmp("stall_count", stall_count, mCount[31:0]);
    pend = '{v: de_valid && !(sa | sb) && !flush, rd: int'(de_rd), rw: de_reg_write, ld: de_is_load};
    pendHold  = hold;
    pendStall = sa | sb;
  endtask

  task automatic advance();
    if (pendStall && mCount < 64'h0000_0000_FFFF_FFFF) mCount++;
    if (!pendHold) begin
      hist.push_front(pend);
      void'(hist.pop_back());
    end
  endtask

  task automatic idle();
    de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0;
    de_rd = 0; de_reg_write = 0; de_is_load = 0; hold = 0; flush = 0;
  endtask

  // One cycle: model follows the edge, inputs change 1ns later, outputs sampled at negedge.
  task automatic step(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                      input bit u2, input bit [4:0] rd, input bit rw, input bit ld,
                      input bit h, input bit f, input logic [STAGES*XLEN-1:0] sd);
    @(posedge CLK);
    advance();
    #1;
    de_valid = v; de_rs1 = r1; de_rs1_used = u1; de_rs2 = r2; de_rs2_used = u2;
    de_rd = rd; de_reg_write = rw; de_is_load = ld; hold = h; flush = f; stage_data = sd;
    @(negedge CLK);
    check();
  endtask

  // Called between edges; the stall drop is observed before the inputs are idled.
  task automatic do_reset();
    #1 RESET = 1'b1;
    #1;
    cmp("rst_stall", {31'd0, stall}, 32'd0);
    cmp("rst_count", stall_count, 32'd0);
    cmp("rst_hit_a", {31'd0, fwd_a_hit}, 32'd0);
    idle();
    model_reset();
    #1 RESET = 1'b0;
  endtask

  function automatic logic [STAGES*XLEN-1:0] rnd_data();
    logic [STAGES*XLEN-1:0] r;
    for (int i = 0; i < STAGES; i++) r[i*XLEN +: XLEN] = $urandom;
    return r;
  endfunction

  initial begin
    idle();
    stage_data = '0;
    RESET = 1'b1;
    model_reset();
    @(negedge CLK);
    do_reset();

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rnd_data());
    cmp("idle_stall", {31'd0, stall}, 32'd0);
    cmp("idle_data", fwd_a_data, 32'd0);

    // x0 producer never matches
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, rnd_data());
    step(1, 0, 1, 0, 0, 3, 1, 0, 0, 0, rnd_data());
    cmp("x0_stall", {31'd0, stall}, 32'd0);
    cmp("x0_hit", {31'd0, fwd_a_hit}, 32'd0);

`ifdef OTTER_HAZARD_FWD_EN
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, rnd_data());
    step(1, 5, 1, 0, 0, 9, 1, 0, 0, 0, {32'h0, 32'h0, 32'h0000_0011});
    cmp("ex_hit", {31'd0, fwd_a_hit}, 32'd1);
    cmp("ex_data", fwd_a_data, 32'h11);
    cmp("ex_stall", {31'd0, stall}, 32'd0);

    do_reset();
    step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, rnd_data());
    step(1, 0, 0, 6, 1, 8, 1, 0, 0, 0, rnd_data());
    cmp("lu_stall", {31'd0, stall}, 32'd1);
    step(1, 0, 0, 6, 1, 8, 1, 0, 0, 0, {32'h0, 32'hDEAD_BEEF, 32'h0});
    cmp("lu_stall2", {31'd0, stall}, 32'd0);
    cmp("lu_hit", {31'd0, fwd_b_hit}, 32'd1);
    cmp("lu_data", fwd_b_data, 32'hDEAD_BEEF);
    cmp("lu_count", stall_count, 32'd1);

    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, rnd_data());
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, rnd_data());
    step(1, 7, 1, 0, 0, 1, 1, 0, 0, 0, {32'h0, 32'hAAAA_AAAA, 32'hBBBB_BBBB});
    cmp("young_data", fwd_a_data, 32'hBBBB_BBBB);

    step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, rnd_data());
    step(1, 0, 0, 6, 1, 2, 1, 0, 0, 1, rnd_data());
    cmp("fl_stall", {31'd0, stall}, 32'd1);
    step(1, 0, 0, 6, 1, 2, 1, 0, 0, 0, rnd_data());
    cmp("fl_after", {31'd0, stall}, 32'd0);
    cmp("fl_hit", {31'd0, fwd_b_hit}, 32'd1);
`else
    do_reset();
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, rnd_data());
    for (int i = 0; i < 3; i++) begin
      step(1, 5, 1, 0, 0, 9, 1, 0, 0, 0, rnd_data());
      cmp("nf_stall", {31'd0, stall}, 32'd1);
      cmp("nf_hit", {31'd0, fwd_a_hit}, 32'd0);
    end
    step(1, 5, 1, 0, 0, 9, 1, 0, 0, 0, rnd_data());
    cmp("nf_release", {31'd0, stall}, 32'd0);
    cmp("nf_count", stall_count, 32'd3);
`endif

    do_reset();
    step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, rnd_data());
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 6, 1, 4, 1, 0, 1, 0, rnd_data());
      cmp("hold_stall", {31'd0, stall}, 32'd1);
    end
    step(1, 0, 0, 6, 1, 4, 1, 0, 1, 0, rnd_data());
    cmp("hold_count", stall_count, 32'd3);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
           $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, rnd_data());
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/otter_hazard_unit.md
# otter_hazard_unit

Parametrised hazard and forwarding unit for the pipelined OTTER RV32I core. It keeps its own shadow scoreboard of in-flight destination registers, one entry per post-decode stage. Each cycle it decides whether the instruction in decode must stall (load-use, or any RAW hazard when forwarding is compiled out) or which stage supplies each operand. It sits beside the decode/execute boundary and drives the operand forwarding muxes and the fetch/decode stall.

## Interface

Parameters:
- XLEN, 32, datapath width.
- STAGES, 3, tracked post-decode stages: entry 0 = EX, 1 = MEM, …, STAGES-1 = WB. Legal range 2..6.
- LOAD_READY, 1, first entry index at which a load result is valid on `stage_data`. Must be ≥1 and <STAGES.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high; clears all state.
- de_valid  in  1  decode holds a real instruction.
- de_rs1, de_rs2  in  5 each  source register addresses.
- de_rs1_used, de_rs2_used  in  1 each  source is actually read.
- de_rd  in  5  destination register.
- de_reg_write  in  1  instruction writes rd.
- de_is_load  in  1  instruction is a LOAD.
- hold  in  1  downstream freeze (memory wait): scoreboard does not advance.
- flush  in  1  taken branch/jump resolved in EX: the decode instruction is killed.
- stage_data  in  STAGES*XLEN  result currently held by each stage; slice k = entry k.
- stall  out  1  decode must not advance this cycle.
- fwd_a_hit, fwd_b_hit  out  1 each  operand taken from the pipeline, not the register file.
- fwd_a_data, fwd_b_data  out  XLEN each  forwarded operand value.
- stall_count  out  32  saturating count of cycles in which `stall` was asserted.

## Operation

- Entry fields: valid, rd, reg_write, is_load.
- Match for rs1 on entry k: de_valid && de_rs1_used && de_rs1≠0 && valid[k] && reg_write[k] && rd[k]==de_rs1. rs2 is handled the same way.
- Priority: the lowest k (youngest) match wins. Older matches are ignored.
- With forwarding enabled:
  - If the winning entry is a load with k<LOAD_READY: stall=1, hit=0.
  - Otherwise: hit=1, data=stage_data slice k.
  - stall is the OR over both operands.
- No match: hit=0, data=0.
- x0 never matches, including when de_rd=0 was issued with reg_write=1.
- Advance rule, evaluated at the posedge when hold=0:
  - Entries shift k→k+1. Entry STAGES-1 retires.
  - Entry 0 loads the decode instruction only if de_valid && !stall && !flush. Otherwise entry 0 becomes a bubble (valid=0).
- hold=1: all entries keep their values. stall_count still counts. flush is ignored, because the pipeline must re-present it.
- flush and stall in the same cycle: a bubble is inserted. flush wins.
- stall_count increments when stall=1 (hold does not matter) and saturates at 0xFFFF_FFFF.

## Timing

- stall, fwd_*_hit and fwd_*_data are purely combinational from the decode inputs, the current entries and stage_data. They have zero-cycle latency.
- The scoreboard updates one cycle after issue. An instruction issued at edge n is visible as entry 0 during cycle n+1.
- Load-use penalty is LOAD_READY cycles of stall. With the defaults, a dependent instruction immediately after a load stalls exactly 1 cycle and then forwards from entry 1.
- Reset (asserted asynchronously, mid-operation included): all entries become invalid and stall_count=0. Outputs therefore read stall=0, hit=0, data=0 until new issues occur.
- Deassertion of RESET is synchronised by the system. The first issue is captured at the first rising edge after release.

## Configuration

- OTTER_HAZARD_FWD_EN defined: forwarding as described above.
- Not defined:
  - fwd_*_hit and fwd_*_data are tied to 0.
  - Any match on any entry asserts stall, so the dependent instruction waits until the producer retires past WB.
  - Load status is irrelevant.

## Test plan

- Forward from EX: issue addi x5 (rd=5, reg_write=1). Next cycle decode rs1=5 with stage_data[0]=0x0000_0011 → fwd_a_hit=1, fwd_a_data=0x11, stall=0.
- Load-use: issue lw x6. Next cycle decode rs2=6 → stall=1 for 1 cycle, then fwd_b_hit=1 with data from slice 1 (drive 0xDEAD_BEEF), and stall_count=1.
- Youngest wins: issue x7←A, then x7←B back-to-back, then decode rs1=7 → data from slice 0, not slice 1.
- x0 and flush:
  - rd=0 producer, then rs1=0 → hit=0, stall=0.
  - flush with a pending load-use stall → stall=1 this cycle, entry 0 bubble next cycle, no stall afterwards.
- hold and async reset:
  - hold=1 for 3 cycles with a load in entry 0 → stall persists and stall_count reaches 3.
  - Assert RESET between edges → stall drops to 0 immediately and stall_count=0.
- Compiled without OTTER_HAZARD_FWD_EN (STAGES=3): ALU producer, then dependent → stall for 3 cycles, hit=0 throughout.
